// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode classes, stage states, defaults.
package cpu_pkg;

  localparam int DEF_DATA_W = 16;

  localparam logic [5:0] OP_LOAD  = 6'b010100;
  localparam logic [5:0] OP_STORE = 6'b010101;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_e;

  function automatic logic is_wb(input logic [5:0] op);
    logic r;
    r = 1'b0;
    if (op[5:4] == 2'b00)
      r = (op != 6'b000011) && (op != 6'b001011);
    else if (op == 6'b010110)
      r = 1'b1;
    else if (op >= 6'b011001 && op <= 6'b011011)
      r = 1'b1;
    return r;
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory req/ack bus between a bus master and memory.
interface mem_wb_stage_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_rdata, dm_ack
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_rdata, dm_ack
    );
endinterface

// File: rtl/mem_timeout_ctr.sv
// Bounded wait counter; expire flags the last allowed cycle.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] count;

    assign expire = (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= expire ? '0 : count + CW'(1);
    end
endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: load/store over req/ack bus, RF writeback.
module mem_wb_stage
  import cpu_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = 8,
    parameter int REG_AW  = 3,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_ex,
    input  logic [5:0]        op_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] DM_data,
    mem_wb_stage_if.master    dm,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              err
);
    mem_state_e        state_q, state_d;
    logic [REG_AW-1:0] pend_rd;
    logic              pend_ld;
    logic              accept;
    logic              expire;
    logic              ctr_en;

    assign stall = (state_q == REQ);

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept),
        .en     (ctr_en),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ctr_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                accept = valid_ex && is_mem(op_ex);
                if (accept)
                    state_d = REQ;
            end
            REQ: begin
                ctr_en = 1'b1;
                if (dm.dm_ack || expire)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dm.dm_req   <= 1'b0;
            dm.dm_we    <= 1'b0;
            dm.dm_addr  <= '0;
            dm.dm_wdata <= '0;
            pend_rd     <= '0;
            pend_ld     <= 1'b0;
            wb_en       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            err         <= 1'b0;
        end else begin
            wb_en <= 1'b0;
            if (state_q == IDLE) begin
                unique case (1'b1)
                    (valid_ex && is_wb(op_ex)): begin
                        wb_en   <= 1'b1;
                        wb_addr <= rd_ex;
                        wb_data <= ans_ex;
                    end
                    accept: begin
                        dm.dm_req   <= 1'b1;
                        dm.dm_we    <= (op_ex == OP_STORE);
                        dm.dm_addr  <= ans_ex[ADDR_W-1:0];
                        dm.dm_wdata <= DM_data;
                        pend_rd     <= rd_ex;
                        pend_ld     <= (op_ex == OP_LOAD);
                    end
                    default: ;
                endcase
            end else if (dm.dm_ack) begin
                // Load data is taken in the ack cycle itself
                dm.dm_req <= 1'b0;
                if (pend_ld) begin
                    wb_en   <= 1'b1;
                    wb_addr <= pend_rd;
                    wb_data <= dm.dm_rdata;
                end
            end else if (expire) begin
                dm.dm_req <= 1'b0;
                err       <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with immediate-assertion checks.
module tb_mem_wb_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_ex;
    logic [5:0]  op_ex;
    logic [2:0]  rd_ex;
    logic [15:0] ans_ex;
    logic [15:0] DM_data;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        stall;
    logic        err;

    int n_run  = 0;
    int n_fail = 0;

    mem_wb_stage_if #(.DATA_W(16), .ADDR_W(8)) dm ();

    mem_wb_stage dut (
        .clk      (clk),
        .reset    (reset),
        .valid_ex (valid_ex),
        .op_ex    (op_ex),
        .rd_ex    (rd_ex),
        .ans_ex   (ans_ex),
        .DM_data  (DM_data),
        .dm       (dm.master),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .stall    (stall),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        valid_ex    = 1'b0;
        op_ex       = 6'b0;
        rd_ex       = 3'd0;
        ans_ex      = 16'h0;
        DM_data     = 16'h0;
        dm.dm_rdata = 16'h0;
        dm.dm_ack   = 1'b0;
        #2;
        chk("rst_req", dm.dm_req, 0);
        chk("rst_wb", wb_en, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall, 0);
        chk("rst_addr", dm.dm_addr, 0);
        chk("rst_wbdata", wb_data, 0);
        tick();
        tick();
        reset = 1'b0;

        // plain ALU writeback
        valid_ex = 1'b1; op_ex = 6'b000000;
        rd_ex = 3'd3; ans_ex = 16'h1234;
        tick();
        chk("wb_en", wb_en, 1);
        chk("wb_addr", wb_addr, 3);
        chk("wb_data", wb_data, 16'h1234);
        chk("wb_stall", stall, 0);
        valid_ex = 1'b0;
        tick();
        chk("wb_once", wb_en, 0);

        // load acked in third REQ cycle
        valid_ex = 1'b1; op_ex = OP_LOAD;
        rd_ex = 3'd5; ans_ex = 16'h0042;
        tick();
        valid_ex = 1'b0;
        chk("ld_req", dm.dm_req, 1);
        chk("ld_addr", dm.dm_addr, 8'h42);
        chk("ld_we", dm.dm_we, 0);
        chk("ld_stall1", stall, 1);
        tick();
        chk("ld_stall2", stall, 1);
        chk("ld_nowb", wb_en, 0);
        tick();
        chk("ld_stall3", stall, 1);
        dm.dm_ack = 1'b1; dm.dm_rdata = 16'hBEEF;
        tick();
        dm.dm_ack = 1'b0; dm.dm_rdata = 16'h0;
        chk("ld_wb_en", wb_en, 1);
        chk("ld_wb_addr", wb_addr, 5);
        chk("ld_wb_data", wb_data, 16'hBEEF);
        chk("ld_req_off", dm.dm_req, 0);
        chk("ld_stall_off", stall, 0);

        // store, then a held AND
        valid_ex = 1'b1; op_ex = OP_STORE; rd_ex = 3'd1;
        ans_ex = 16'h0010; DM_data = 16'hA5A5;
        tick();
        chk("st_req", dm.dm_req, 1);
        chk("st_we", dm.dm_we, 1);
        chk("st_wdata", dm.dm_wdata, 16'hA5A5);
        chk("st_addr", dm.dm_addr, 8'h10);
        chk("st_stall", stall, 1);
        op_ex = 6'b000100; rd_ex = 3'd2;
        ans_ex = 16'h00F0; DM_data = 16'h0;
        dm.dm_ack = 1'b1;
        tick();
        dm.dm_ack = 1'b0;
        chk("st_nowb", wb_en, 0);
        chk("st_req_off", dm.dm_req, 0);
        chk("st_stall_off", stall, 0);
        tick();
        valid_ex = 1'b0;
        chk("and_wb_en", wb_en, 1);
        chk("and_wb_addr", wb_addr, 2);
        chk("and_wb_data", wb_data, 16'h00F0);
        chk("and_stall", stall, 0);
        tick();
        chk("and_once", wb_en, 0);

        // load timeout: 16 REQ cycles then abort
        valid_ex = 1'b1; op_ex = OP_LOAD;
        rd_ex = 3'd6; ans_ex = 16'h0077;
        tick();
        valid_ex = 1'b0;
        chk("to_req1", dm.dm_req, 1);
        for (int i = 2; i <= 16; i++) begin
            tick();
            chk($sformatf("to_req%0d", i), dm.dm_req, 1);
            chk($sformatf("to_nowb%0d", i), wb_en, 0);
        end
        tick();
        chk("to_req_off", dm.dm_req, 0);
        chk("to_err", err, 1);
        chk("to_nowb", wb_en, 0);
        chk("to_stall", stall, 0);
        dm.dm_ack = 1'b1; dm.dm_rdata = 16'h5555;
        tick();
        dm.dm_ack = 1'b0;
        chk("to_err_sticky", err, 1);
        chk("idle_ack_nowb", wb_en, 0);

        // NOP class opcode
        valid_ex = 1'b1; op_ex = 6'b010000; rd_ex = 3'd4;
        tick();
        valid_ex = 1'b0;
        chk("nop_wb", wb_en, 0);
        chk("nop_req", dm.dm_req, 0);
        valid_ex = 1'b1; op_ex = 6'b000011;
        tick();
        valid_ex = 1'b0;
        chk("op03_wb", wb_en, 0);
        valid_ex = 1'b1; op_ex = 6'b011010; ans_ex = 16'h0C0C;
        tick();
        valid_ex = 1'b0;
        chk("op1a_wb", wb_en, 1);
        chk("op1a_data", wb_data, 16'h0C0C);

        // reset mid-transaction
        valid_ex = 1'b1; op_ex = OP_LOAD;
        rd_ex = 3'd7; ans_ex = 16'h0033;
        tick();
        valid_ex = 1'b0;
        chk("mid_req", dm.dm_req, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_req", dm.dm_req, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_err", err, 0);
        tick();
        reset = 1'b0;
        dm.dm_ack = 1'b1; dm.dm_rdata = 16'h9999;
        tick();
        dm.dm_ack = 1'b0;
        chk("mid_late_ack_wb", wb_en, 0);
        chk("mid_late_req", dm.dm_req, 0);
        tick();
        chk("mid_quiet_wb", wb_en, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
